// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback bus of the scoreboarded register file.
// master = decode/writeback side, slave = register file.
interface reg_file_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) ();
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   reg_rd_addr;
    logic [NRD*XLEN-1:0] reg_out;
    logic [NRD-1:0]      reg_rd_pend;
    logic                reg_wr_en;
    logic [AW-1:0]       reg_wr_addr;
    logic [XLEN-1:0]     reg_in;
    logic                reg_rsv_en;
    logic [AW-1:0]       reg_rsv_addr;
    logic                reg_busy;

    modport master (
        output reg_rd_addr, reg_wr_en, reg_wr_addr, reg_in,
        output reg_rsv_en, reg_rsv_addr,
        input  reg_out, reg_rd_pend, reg_busy
    );

    modport slave (
        input  reg_rd_addr, reg_wr_en, reg_wr_addr, reg_in,
        input  reg_rsv_en, reg_rsv_addr,
        output reg_out, reg_rd_pend, reg_busy
    );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: NREGS x XLEN register file, NRD async read ports, one write
// port, per-register pending scoreboard, post-reset clear sweep.
// Ports: reg_clk, reg_rst (sync, active-high), bus (reg_file_sb_if.slave).
// Optional: `define REG_BYPASS_EN forwards a same-cycle write to readers.
module reg_file_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  logic          reg_clk,
    input  logic          reg_rst,
    reg_file_sb_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ptr_q;
    logic [XLEN-1:0]     mem [NREGS];
    logic [NREGS-1:0]    pend_q, pend_d;
    logic                busy;
    logic                wr_ok;
    logic                rsv_ok;
    logic [NRD*XLEN-1:0] out_v;
    logic [NRD-1:0]      pend_v;

    // Reset shows as busy in the same cycle so readers never see stale data.
    assign busy   = reg_rst || (state_q != READY);
    assign wr_ok  = !busy && bus.reg_wr_en && (bus.reg_wr_addr != '0);
    assign rsv_ok = !busy && bus.reg_rsv_en && (bus.reg_rsv_addr != '0);

    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            state_q <= CLEAR;
            ptr_q   <= AW'(1);
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (state_q == CLEAR)
                ptr_q <= ptr_q + AW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && ptr_q == AW'(NREGS - 1))
            state_d = READY;
    end

    // Reservation is applied after the write clear: a newer producer wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok)
            pend_d[bus.reg_wr_addr] = 1'b0;
        if (rsv_ok)
            pend_d[bus.reg_rsv_addr] = 1'b1;
    end

    // No reset on the array so it can map to distributed RAM.
    always_ff @(posedge reg_clk) begin
        if (!reg_rst && state_q == CLEAR)
            mem[ptr_q] <= '0;
        else if (wr_ok)
            mem[bus.reg_wr_addr] <= bus.reg_in;
    end

    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rp;
        out_v  = '0;
        pend_v = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = bus.reg_rd_addr[k*AW +: AW];
            rd = (ra == '0) ? '0 : mem[ra];
            rp = pend_q[ra];
`ifdef REG_BYPASS_EN
            if (wr_ok && bus.reg_wr_addr == ra) begin
                rd = bus.reg_in;
                rp = 1'b0;
            end
`endif
            if (busy) begin
                rd = '0;
                rp = 1'b0;
            end
            out_v[k*XLEN +: XLEN] = rd;
            pend_v[k]             = rp;
        end
    end

    assign bus.reg_out     = out_v;
    assign bus.reg_rd_pend = pend_v;
    assign bus.reg_busy    = busy;
endmodule
